// File: rtl/race_pkg.sv
// Shared encodings for the box-race sequencer: state codes, winner codes and
// helpers that split a box count into BCD digits.
package race_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_PENALTY = 3'd2;
  localparam logic [2:0] S_PAUSE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] W_NONE   = 2'b00;
  localparam logic [1:0] W_PLAYER = 2'b01;
  localparam logic [1:0] W_PC     = 2'b10;

  function automatic logic [3:0] bcd_tens(input int n);
    return 4'((n / 10) % 10);
  endfunction

  function automatic logic [3:0] bcd_ones(input int n);
    return 4'(n % 10);
  endfunction

  localparam logic [3:0] DEF_TENS = bcd_tens(32);
  localparam logic [3:0] DEF_ONES = bcd_ones(32);

endpackage

// File: rtl/key_edge_sync.sv
// Brings an asynchronous key into the clock domain and emits a registered
// one-cycle pulse on its rising edge (pulse appears 3 cycles after the raw rise).
module key_edge_sync (
  input  logic clock,
  input  logic resetn,
  input  logic key,
  output logic level,
  output logic key_edge
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;
  logic edge_p2;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      edge_p2 <= 1'b0;
    end else begin
      sync_p0 <= key;
      sync_p1 <= sync_p0;
      // edge detect stage: compare synchronised level against its delayed copy
      prev_p2 <= sync_p1;
      edge_p2 <= sync_p1 & ~prev_p2;
    end
  end

  assign level    = sync_p1;
  assign key_edge = edge_p2;

endmodule

// File: rtl/race_game_ctrl.sv
// Game sequencer for the two-player box race: qualifies key presses against
// the next box, counts remaining boxes in BCD, applies lockouts, picks a winner.
module race_game_ctrl
  import race_pkg::*;
#(
  parameter int NUM_BOXES      = 32,
  parameter int PENALTY_CYCLES = 25_000_000,
  parameter int PEN_W          = 25
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       box,
  input  logic       pc_ended,
  output logic       load_n,
  output logic       shift,
  output logic       run_en,
  output logic [3:0] player_ones,
  output logic [3:0] player_tens,
  output logic       penalty,
  output logic [1:0] winner,
  output logic [2:0] state_out
);

  localparam logic [3:0]       INIT_TENS = bcd_tens(NUM_BOXES);
  localparam logic [3:0]       INIT_ONES = bcd_ones(NUM_BOXES);
  localparam logic [PEN_W-1:0] PEN_LOAD  = PEN_W'(PENALTY_CYCLES - 1);

  logic             left_lvl, left_edge;
  logic             right_lvl, right_edge;
  logic [2:0]       state;
  logic             origin_pen;
  logic [PEN_W-1:0] pen_cnt;
  logic [3:0]       tens, ones;
  logic             shift_p0, shift_p1;
  logic [1:0]       win_r;
  logic             stale, le, re, correct, wrong, last_press;

  key_edge_sync u_left (
    .clock    (clock),
    .resetn   (resetn),
    .key      (key_left),
    .level    (left_lvl),
    .key_edge (left_edge)
  );

  key_edge_sync u_right (
    .clock    (clock),
    .resetn   (resetn),
    .key      (key_right),
    .level    (right_lvl),
    .key_edge (right_edge)
  );

  function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
    if (o == 4'd0) return {t - 4'd1, 4'd9};
    else           return {t, o - 4'd1};
  endfunction

  // box is stale during the shift pulse and the cycle after it
  assign stale      = shift_p0 | shift_p1;
  assign le         = left_edge & ~stale;
  assign re         = right_edge & ~stale;
  assign correct    = (le & ~re & ~box) | (re & ~le & box);
  assign wrong      = (le | re) & ~correct;
  assign last_press = correct && (tens == 4'd0) && (ones == 4'd1);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      origin_pen <= 1'b0;
      pen_cnt    <= '0;
      tens       <= INIT_TENS;
      ones       <= INIT_ONES;
      shift_p0   <= 1'b0;
      shift_p1   <= 1'b0;
      win_r      <= W_NONE;
    end else begin
      shift_p0 <= 1'b0;
      shift_p1 <= shift_p0;
      case (state)
        S_IDLE: begin
          tens  <= INIT_TENS;
          ones  <= INIT_ONES;
          win_r <= W_NONE;
          if (start && !left_lvl && !right_lvl) state <= S_RUN;
        end
        S_RUN: begin
          if (last_press) begin
            state        <= S_DONE;
            win_r        <= W_PLAYER;
            {tens, ones} <= 8'h00;
          end else if (pc_ended) begin
            state <= S_DONE;
            win_r <= W_PC;
          end else if (!start) begin
            state      <= S_PAUSE;
            origin_pen <= 1'b0;
          end else if (correct) begin
            {tens, ones} <= bcd_dec(tens, ones);
            shift_p0     <= 1'b1;
          end else if (wrong) begin
            state   <= S_PENALTY;
            pen_cnt <= PEN_LOAD;
          end
        end
        S_PENALTY: begin
          if (pc_ended) begin
            state <= S_DONE;
            win_r <= W_PC;
          end else if (!start) begin
            state      <= S_PAUSE;
            origin_pen <= 1'b1;
          end else if (pen_cnt == '0) begin
            state <= S_RUN;
          end else begin
            pen_cnt <= pen_cnt - 1'b1;
          end
        end
        S_PAUSE: begin
          if (start) state <= origin_pen ? S_PENALTY : S_RUN;
        end
        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
            tens  <= INIT_TENS;
            ones  <= INIT_ONES;
            win_r <= W_NONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign load_n      = (state != S_IDLE);
  assign run_en      = (state == S_RUN) || (state == S_PENALTY);
  assign penalty     = (state == S_PENALTY) || ((state == S_PAUSE) && origin_pen);
  assign shift       = shift_p0;
  assign winner      = win_r;
  assign player_tens = tens;
  assign player_ones = ones;
  assign state_out   = state;

endmodule
